poly1305_aead_block_formatter: RTL
==================================

// Module: poly1305_aead_block_formatter
// PURPOSE
//  Upstream feeder of the ChaCha20-Poly1305 accumulator. Packs a 32-bit little-endian
//  byte stream (AAD segment, then ciphertext segment) into 130-bit Poly1305 message
//  blocks per RFC 8439 AEAD: each segment is zero-padded to 16 bytes, bit 128 is set on
//  every block, and a final length block {le64(ct_len), le64(aad_len)} closes the message.
// PARAMETERS
//  LEN_W   64  width of the byte-length counters; wraps modulo 2^LEN_W, zero-extended to 64 in the length block
//  HI_BIT  1   1: set block bit 128 (Poly1305 pad bit); 0: bits [129:128] always 0
// PORTS
//  clk       in   1    clock
//  reset_n   in   1    asynchronous, active-low reset
//  start     in   1    begin a new message; honoured only in IDLE
//  s_valid   in   1    input beat valid
//  s_ready   out  1    input beat accepted when s_valid & s_ready
//  s_data    in   32   message bytes; s_data[7:0] is the earliest byte
//  s_keep    in   4    byte enables, contiguous from bit 0: 4'h0/1/3/7/F
//  s_last    in   1    last beat of the current segment (AAD or CT)
//  m_valid   out  1    block valid
//  m_ready   in   1    downstream accepts block when m_valid & m_ready
//  m_block   out  130  block value; message byte i at bits [8i+7:8i]
//  m_final   out  1    qualifies m_block as the length block (last of message)
//  busy      out  1    high in every state except IDLE
// BEHAVIOUR
//  Reset: state=IDLE, s_ready=0, m_valid=0, m_final=0, m_block=0, busy=0, fill=0, lengths=0.
//  FSM: IDLE -start-> AAD -accepted s_last-> CT -accepted s_last-> LEN -length block
//   handshaken-> IDLE. start outside IDLE is ignored; start in IDLE clears both length
//   counters and the buffer.
//  Buffer: 128-bit accumulator plus fill count 0..16 bytes. An accepted beat writes
//   popcount(s_keep) bytes at byte offset fill; the segment's length counter adds the same.
//  s_keep other than 4'hF is legal only with s_last; other keep values are a protocol
//   error with undefined results. keep=0 with s_last denotes an empty segment (no bytes).
//  Block close: at fill==16, or on s_last with fill>0 (remaining bytes zero). The
//   closed block becomes pending. s_last with fill==0 closes no block.
//  Output: one holding register. A pending block moves into it in the cycle the
//   register is empty or handshaken (m_valid&m_ready). m_valid rises the cycle after
//   the completing beat when the register is free. 0x01 pad: m_block[128]=HI_BIT, [129]=0.
//  s_ready = (state==AAD || state==CT) && !pending. With m_ready held high, sustained
//   throughput is one beat per cycle with no bubbles.
//  Segment switch: s_last in AAD leaves the next beat at fill 0 (CT starts on a fresh
//   block). s_last in CT moves to LEN. In LEN, after the last CT block (if any) has
//   left the holding register, the length block
//   {1'b0, HI_BIT, zext64(ct_len), zext64(aad_len)} loads with m_final=1. m_final is 0
//   for all data blocks.
//  Backpressure: m_block/m_final stay stable while m_valid & !m_ready. Blocks are never
//   dropped or reordered.
//  Reset mid-message: everything returns to reset values at once; a partial message is
//   discarded and no block is emitted for it.
// TESTING
//  1 start; AAD 3 beats keep F (12B, last); CT 4 beats keep F (16B, last) -> blocks:
//    {2'b01,32'h0,aad[95:0]}, {2'b01,ct[127:0]}, {2'b01,64'd16,64'd12} with m_final=1 on 3rd only.
//  2 Empty AAD (one beat keep=0,last) then CT 1 beat s_data=32'hAABBCCDD keep=1 last ->
//    {2'b01,120'h0,8'hDD} then length block {2'b01,64'd5?}: no -> CT=1B: {2'b01,64'd1,64'd0}.
//  3 CT 64B with m_ready tied 1 -> s_ready never drops; 4 data blocks then LEN, back-to-back.
//  4 m_ready low 10 cycles after first CT block -> s_ready drops once a block is pending;
//    m_block stable; after release all blocks arrive in order, correct lengths.
//  5 Assert reset_n low during CT beat 2 -> all outputs 0 next edge; new start + 4B AAD/4B CT
//    -> correct blocks, length block {2'b01,64'd4,64'd4}.
//  6 start pulsed while busy during CT -> ignored; length counters and output unchanged.

Source files
------------

// File: rtl/poly1305_aead_block_formatter_if.sv
// poly1305_aead_block_formatter_if: byte-stream input and Poly1305 block output channels
interface poly1305_aead_block_formatter_if;
  logic         s_valid;
  logic         s_ready;
  logic [31:0]  s_data;
  logic [3:0]   s_keep;
  logic         s_last;
  logic         m_valid;
  logic         m_ready;
  logic [129:0] m_block;
  logic         m_final;
  modport master (
    output s_valid, s_data, s_keep, s_last, m_ready,
    input  s_ready, m_valid, m_block, m_final
  );
  modport slave (
    input  s_valid, s_data, s_keep, s_last, m_ready,
    output s_ready, m_valid, m_block, m_final
  );
endinterface

// File: rtl/poly1305_aead_block_formatter.sv
// poly1305_aead_block_formatter: packs AAD/CT byte stream into padded 130-bit Poly1305 blocks plus length block
module poly1305_aead_block_formatter #(
  parameter int LEN_W  = 64,
  parameter bit HI_BIT = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  output logic busy,
  poly1305_aead_block_formatter_if.slave bus
);
  // FIN holds the length block until it is handshaken, then returns to IDLE
  typedef enum logic [2:0] {IDLE, AAD, CT, LEN, FIN} state_t;
  state_t           state;
  logic [127:0]     buf_q, pend_blk, merged;
  logic [4:0]       fill, nb, new_fill;
  logic             pend, acc, close, out_free;
  logic [31:0]      masked;
  logic [LEN_W-1:0] aad_len, ct_len;
  assign bus.s_ready = (state == AAD || state == CT) && !pend;
  assign busy        = state != IDLE;
  // merge the incoming beat at the current fill offset and decide whether it closes a block
  always_comb begin
    nb       = bus.s_keep[3] ? 5'd4 : bus.s_keep[2] ? 5'd3 : bus.s_keep[1] ? 5'd2 : bus.s_keep[0] ? 5'd1 : 5'd0;
    masked   = bus.s_data & {{8{bus.s_keep[3]}}, {8{bus.s_keep[2]}}, {8{bus.s_keep[1]}}, {8{bus.s_keep[0]}}};
    merged   = buf_q | ({96'h0, masked} << {fill, 3'b000});
    new_fill = fill + nb;
    acc      = bus.s_valid && bus.s_ready;
    close    = new_fill == 5'd16 || (bus.s_last && new_fill != 5'd0);
    out_free = !bus.m_valid || bus.m_ready;
  end
  // message FSM, accumulator, pending slot and output holding register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      buf_q       <= '0;
      pend_blk    <= '0;
      fill        <= '0;
      pend        <= 1'b0;
      aad_len     <= '0;
      ct_len      <= '0;
      bus.m_valid <= 1'b0;
      bus.m_block <= '0;
      bus.m_final <= 1'b0;
    end else begin
      if (bus.m_valid && bus.m_ready) begin
        bus.m_valid <= 1'b0;
        bus.m_final <= 1'b0;
      end
      if (pend && out_free) begin
        bus.m_valid <= 1'b1;
        bus.m_block <= {1'b0, HI_BIT, pend_blk};
        pend        <= 1'b0;
      end
      case (state)
        IDLE: if (start) begin
          state   <= AAD;
          aad_len <= '0;
          ct_len  <= '0;
          buf_q   <= '0;
          fill    <= '0;
        end
        AAD, CT: if (acc) begin
          if (state == AAD) aad_len <= aad_len + LEN_W'(nb);
          else ct_len <= ct_len + LEN_W'(nb);
          if (close) begin
            buf_q <= '0;
            fill  <= '0;
            if (out_free) begin
              bus.m_valid <= 1'b1;
              bus.m_block <= {1'b0, HI_BIT, merged};
            end else begin
              pend     <= 1'b1;
              pend_blk <= merged;
            end
          end else begin
            buf_q <= merged;
            fill  <= new_fill;
          end
          if (bus.s_last) state <= (state == AAD) ? CT : LEN;
        end
        LEN: if (!pend && out_free) begin
          bus.m_valid <= 1'b1;
          bus.m_block <= {1'b0, HI_BIT, 64'(ct_len), 64'(aad_len)};
          bus.m_final <= 1'b1;
          state       <= FIN;
        end
        FIN: if (bus.m_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
